// File: rtl/ntt_butterfly.sv
// Radix-2 NTT/INTT butterfly (CT forward / GS inverse) around one shared modular multiplier.
// Twiddles are in the natural domain (plain multiply-then-reduce), so the encoding of 1 is 1.

module mo_mul #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned Q          = 3329,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                  clk_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  output logic [DATA_WIDTH-1:0] p_o
);
  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [PW-1:0]         prod;
  logic [DATA_WIDTH-1:0] red;
  logic [DATA_WIDTH-1:0] pipe_q [LATENCY];

  always_comb begin
    prod = PW'(x_i) * PW'(y_i);
    red  = DATA_WIDTH'(prod % PW'(Q));
  end

  // Reduction happens in the first stage; the remaining stages only pad out the fixed latency.
  always_ff @(posedge clk_i) begin
    pipe_q[0] <= red;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign p_o = pipe_q[LATENCY-1];
endmodule

module ntt_butterfly #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned Q           = 3329,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] w,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out0,
  output logic [DATA_WIDTH-1:0] out1
);
  localparam int unsigned L  = MUL_LATENCY + 1;
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [DW:0] QX = Q[DW:0];

  typedef enum logic {RUN, DRAIN} state_e;

  state_e       state_q, state_d;
  logic         curMode_q, curMode_d;
  logic [L:1]   vld_q;
  logic [L:1]   gs_q;
  logic         busy, modeClash, inFire;

  logic [DW-1:0] aDly_q [MUL_LATENCY];
  logic [DW-1:0] sDly_q [MUL_LATENCY];
  logic [DW-1:0] gsSum_q, gsDiff_q, gsW_q;
  logic [DW-1:0] ctSum_q, ctDiff_q;
  logic [DW-1:0] hold0_q, hold1_q;
  logic [DW-1:0] mulX, mulY, mulP;

  function automatic logic [DW-1:0] modAdd(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QX) s = s - QX;
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] modSub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[DW]) d = d + QX;
    return d[DW-1:0];
  endfunction

  // The op sitting in the output stage no longer touches the multiplier, so it does not block a mode switch.
  assign busy      = |vld_q[L-1:1];
  assign modeClash = in_valid && (mode != curMode_q) && busy;
  assign inFire    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      curMode_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      curMode_q <= curMode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    curMode_d = curMode_q;
    case (state_q)
      RUN: begin
        if (modeClash)     state_d   = DRAIN;
        else if (in_valid) curMode_d = mode;
      end
      DRAIN: begin
        if (!busy) begin
          state_d   = RUN;
          curMode_d = mode;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN) && !modeClash;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      gs_q  <= '0;
    end else begin
      vld_q <= {vld_q[L-1:1], inFire};
      gs_q  <= {gs_q[L-1:1], mode};
    end
  end

  // CT uses the multiplier on its issue cycle, GS one cycle later once a-b is registered.
  always_comb begin
    mulX = b;
    mulY = w;
    if (vld_q[1] && gs_q[1]) begin
      mulX = gsDiff_q;
      mulY = gsW_q;
    end
  end

  mo_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .Q         (Q),
    .LATENCY   (MUL_LATENCY)
  ) u_mul (
    .clk_i(clk),
    .x_i  (mulX),
    .y_i  (mulY),
    .p_o  (mulP)
  );

  always_ff @(posedge clk) begin
    aDly_q[0] <= a;
    sDly_q[0] <= gsSum_q;
    for (int i = 1; i < int'(MUL_LATENCY); i++) begin
      aDly_q[i] <= aDly_q[i-1];
      sDly_q[i] <= sDly_q[i-1];
    end
    gsSum_q  <= modAdd(a, b);
    gsDiff_q <= modSub(a, b);
    gsW_q    <= w;
    ctSum_q  <= modAdd(aDly_q[MUL_LATENCY-1], mulP);
    ctDiff_q <= modSub(aDly_q[MUL_LATENCY-1], mulP);
  end

  // GS results come straight off the multiplier; hold registers keep the last result between pulses.
  always_comb begin
    out_valid = vld_q[L];
    out0      = hold0_q;
    out1      = hold1_q;
    if (vld_q[L]) begin
      if (gs_q[L]) begin
        out0 = sDly_q[MUL_LATENCY-1];
        out1 = mulP;
      end else begin
        out0 = ctSum_q;
        out1 = ctDiff_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold0_q <= '0;
      hold1_q <= '0;
    end else if (vld_q[L]) begin
      hold0_q <= out0;
      hold1_q <= out1;
    end
  end
endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed vectors, drain/reset sequences and a random
// stream compared against a cycle-stamped arithmetic model.

module tb_ntt_butterfly;
  localparam int DW = 12;
  localparam int Q  = 3329;
  localparam int ML = 3;
  localparam int L  = ML + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] a = '0, b = '0, w = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] out0, out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_butterfly #(.DATA_WIDTH(DW), .Q(Q), .MUL_LATENCY(ML)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .w        (w),
    .out_valid(out_valid),
    .out0     (out0),
    .out1     (out1)
  );

  typedef struct {longint t; int o0; int o1;} exp_t;
  typedef struct {bit m; int a; int b; int w; int o0; int o1;} vec_t;

  exp_t   expQ[$];
  longint fireT[$];
  longint cycle = 0;
  bit     drain = 0, lastMode = 0;
  int     lastO0 = 0, lastO1 = 0, outCount = 0;
  bit     monBusy, monDue, monReady;
  int     monE0, monE1, monR0, monR1;
  exp_t   monEntry;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  function automatic void refButterfly(input int ai, input int bi, input int wi, input bit m,
                                       output int o0, output int o1);
    longint t;
    if (!m) begin
      t  = (longint'(bi) * wi) % Q;
      o0 = int'((ai + t) % Q);
      o1 = int'((ai - t + Q) % Q);
    end else begin
      o0 = (ai + bi) % Q;
      o1 = int'((longint'((ai - bi + Q) % Q) * wi) % Q);
    end
  endfunction

  // Model: every accepted op owes a result exactly L cycles later; ops younger than L block a mode switch.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      fireT.delete();
      drain = 0; lastMode = 0; lastO0 = 0; lastO1 = 0;
    end else begin
      while (fireT.size() > 0 && cycle - fireT[0] >= L) void'(fireT.pop_front());
      monBusy  = (fireT.size() != 0);
      monReady = !drain && !(in_valid && (mode != lastMode) && monBusy);
      checkOutput("in_ready", int'(in_ready), int'(monReady));
      if (!drain && in_valid && (mode != lastMode) && monBusy) drain = 1;
      else if (drain && !monBusy) drain = 0;

      monDue = (expQ.size() > 0) && (expQ[0].t == cycle);
      if (monDue) begin
        monE0 = expQ[0].o0; monE1 = expQ[0].o1;
        void'(expQ.pop_front());
        lastO0 = monE0; lastO1 = monE1;
      end else begin
        monE0 = lastO0; monE1 = lastO1;
      end
      checkOutput("out_valid", int'(out_valid), int'(monDue));
      checkOutput("out0", int'(out0), monE0);
      checkOutput("out1", int'(out1), monE1);
      if (out_valid) begin
        outCount++;
        checkOutput("out_range", int'(out0 < DW'(Q) && out1 < DW'(Q)), 1);
      end

      if (in_valid && in_ready) begin
        refButterfly(int'(a), int'(b), int'(w), mode, monR0, monR1);
        monEntry.t = cycle + L; monEntry.o0 = monR0; monEntry.o1 = monR1;
        expQ.push_back(monEntry);
        fireT.push_back(cycle);
        lastMode = mode;
      end
    end
    cycle++;
  end

  task automatic applyStimulus(input int ai, input int bi, input int wi, input bit m);
    @(posedge clk); #1;
    in_valid = 1'b1; mode = m;
    a = DW'(ai); b = DW'(bi); w = DW'(wi);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic driveOp(input bit m);
    @(posedge clk); #1;
    in_valid = 1'b1; mode = m;
    a = DW'($urandom_range(0, Q-1)); b = DW'($urandom_range(0, Q-1)); w = DW'($urandom_range(0, Q-1));
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[8];

  initial begin
    int base, stall, nOps, waitCnt;
    bit accepted, have, curM;

    vecs[0] = '{0, 3000, 500, 1, 171, 2500};
    vecs[1] = '{1, 100, 200, 1, 300, 3229};
    vecs[2] = '{1, 3328, 3328, 1, 3327, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 1, 1, 3328, 0, 2};
    vecs[5] = '{1, 0, 1, 5, 1, 3324};
    vecs[6] = '{0, 3328, 3328, 3328, 0, 3327};
    vecs[7] = '{1, 5, 3328, 2, 4, 12};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out0", int'(out0), 0);
    checkOutput("reset_out1", int'(out1), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].m);
      repeat (L - 1) @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      checkOutput($sformatf("vec%0d_out0", i), int'(out0), vecs[i].o0);
      checkOutput($sformatf("vec%0d_out1", i), int'(out1), vecs[i].o1);
    end

    // Back-to-back CT stream must never stall.
    repeat (2) @(posedge clk);
    base = outCount;
    for (int i = 0; i < 16; i++) begin
      driveOp(1'b0);
      @(negedge clk);
      checkOutput("stream_in_ready", int'(in_ready), 1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (L + 2) @(posedge clk);
    @(negedge clk);
    checkOutput("stream_count", outCount - base, 16);

    // Three CT ops then a GS op: GS waits for the pipeline to drain.
    for (int i = 0; i < 3; i++) driveOp(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; mode = 1'b1; a = DW'(100); b = DW'(200); w = DW'(1);
    stall = 0; accepted = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        break;
      end
      stall++;
      @(posedge clk); #1;
    end
    checkOutput("drain_accepted", int'(accepted), 1);
    checkOutput("drain_stall_cycles", stall, 4);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (L - 1) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_gs_valid", int'(out_valid), 1);
    checkOutput("drain_gs_out0", int'(out0), 300);
    checkOutput("drain_gs_out1", int'(out1), 3229);

    // Reset with ops in flight drops them all.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) driveOp(1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("midrst_out_valid", int'(out_valid), 0);
      checkOutput("midrst_out0", int'(out0), 0);
      checkOutput("midrst_out1", int'(out1), 0);
      checkOutput("midrst_in_ready", int'(in_ready), 1);
    end

    // Random mixed-mode stream with idle gaps; the monitor checks every result.
    nOps = 0; have = 0; curM = 0; waitCnt = 0;
    while (nOps < 10000) begin
      @(posedge clk); #1;
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1; waitCnt = 0;
        if ($urandom_range(0, 15) == 0) curM = ~curM;
        mode = curM;
        a = DW'($urandom_range(0, Q-1)); b = DW'($urandom_range(0, Q-1)); w = DW'($urandom_range(0, Q-1));
      end
      in_valid = have;
      @(negedge clk);
      if (have && in_ready) begin
        have = 0;
        nOps++;
      end else if (have) begin
        waitCnt++;
        if (waitCnt > 2 * L + 2) begin
          checkOutput("rand_accept_timeout", waitCnt, 0);
          have = 0;
          nOps++;
        end
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (L + 3) @(posedge clk);
    @(negedge clk);
    checkOutput("rand_pending_results", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
